hsv_core_issue_gate: RTL and testbench

In-order issue gate placed directly upstream of the core's in-flight instruction FIFO. It accepts one decoded instruction per cycle, holds it in a single register, and tracks per-register pending-write counts in a scoreboard. It releases the instruction on the valid/ready handshake only when no RAW or WAW-overflow hazard exists. Counts are incremented on issue and decremented on commit.

---
 rtl/hsv_core_issue_pkg.sv | 21 ++
 rtl/hsv_core_issue_gate_if.sv | 40 ++++
 rtl/hsv_core_issue_scoreboard.sv | 90 +++++++++
 rtl/hsv_core_issue_gate.sv | 120 ++++++++++++
 tb/tb_hsv_core_issue_gate.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/hsv_core_issue_pkg.sv
// Shared types for the in-order issue gate: register index, FSM state and the
// pending-write saturation limit.
package hsv_core_issue_pkg;

    localparam int REG_COUNT_DEF = 32;
    localparam int REG_IDX_W     = $clog2(REG_COUNT_DEF);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } issue_state_t;

    // Largest count a PENDING_BITS-wide counter may hold.
    function automatic int pending_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/hsv_core_issue_gate_if.sv
// Upstream instruction, downstream FIFO and commit signals of the issue gate.
// The gate uses the slave view; the producer/consumer side uses master.
interface hsv_core_issue_gate_if #(
    parameter int REG_COUNT     = 32,
    parameter int PAYLOAD_WIDTH = 64
);
    localparam int IDX_W = $clog2(REG_COUNT);

    logic                     valid_i;
    logic                     ready_o;
    logic [IDX_W-1:0]         rs1_i;
    logic [IDX_W-1:0]         rs2_i;
    logic [IDX_W-1:0]         rd_i;
    logic                     uses_rs1_i;
    logic                     uses_rs2_i;
    logic                     writes_rd_i;
    logic [PAYLOAD_WIDTH-1:0] payload_i;

    logic                     ready_i;
    logic                     valid_o;
    logic [PAYLOAD_WIDTH-1:0] payload_o;
    logic [IDX_W-1:0]         rd_o;
    logic                     writes_rd_o;

    logic                     commit_valid_i;
    logic [IDX_W-1:0]         commit_rd_i;

    modport master (
        output valid_i, rs1_i, rs2_i, rd_i, uses_rs1_i, uses_rs2_i, writes_rd_i,
               payload_i, ready_i, commit_valid_i, commit_rd_i,
        input  ready_o, valid_o, payload_o, rd_o, writes_rd_o
    );

    modport slave (
        input  valid_i, rs1_i, rs2_i, rd_i, uses_rs1_i, uses_rs2_i, writes_rd_i,
               payload_i, ready_i, commit_valid_i, commit_rd_i,
        output ready_o, valid_o, payload_o, rd_o, writes_rd_o
    );

endinterface

// File: rtl/hsv_core_issue_scoreboard.sv
// Per-register pending-write counters with two hazard query ports; both see
// the write firing this cycle as already counted.
module hsv_core_issue_scoreboard
    import hsv_core_issue_pkg::*;
#(
    parameter  int REG_COUNT    = 32,
    parameter  int PENDING_BITS = 2,
    localparam int IDX_W        = $clog2(REG_COUNT)
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             flush,
    input  logic             inc_valid,
    input  logic [IDX_W-1:0] inc_rd,
    input  logic             dec_valid,
    input  logic [IDX_W-1:0] dec_rd,
    input  logic             a_uses_rs1,
    input  logic [IDX_W-1:0] a_rs1,
    input  logic             a_uses_rs2,
    input  logic [IDX_W-1:0] a_rs2,
    input  logic             a_writes_rd,
    input  logic [IDX_W-1:0] a_rd,
    output logic             a_hazard,
    input  logic             b_uses_rs1,
    input  logic [IDX_W-1:0] b_rs1,
    input  logic             b_uses_rs2,
    input  logic [IDX_W-1:0] b_rs2,
    input  logic             b_writes_rd,
    input  logic [IDX_W-1:0] b_rd,
    output logic             b_hazard
);

    localparam logic [PENDING_BITS:0] CNT_SAT = (PENDING_BITS + 1)'(pending_max(PENDING_BITS));

    logic [PENDING_BITS-1:0] cnt_q [REG_COUNT];
    logic [REG_COUNT-1:0]    inc_vec;
    logic [REG_COUNT-1:0]    dec_vec;
    logic                    inc_hit;

    assign inc_hit = inc_valid && (inc_rd != '0);

    function automatic logic [PENDING_BITS:0] eff_cnt(input logic [PENDING_BITS-1:0] c,
                                                      input logic hit);
        return {1'b0, c} + {{PENDING_BITS{1'b0}}, hit};
    endfunction

    function automatic logic hazard_f(
        input logic u1, input logic [IDX_W-1:0] r1, input logic [PENDING_BITS:0] c1,
        input logic u2, input logic [IDX_W-1:0] r2, input logic [PENDING_BITS:0] c2,
        input logic wr, input logic [IDX_W-1:0] rd, input logic [PENDING_BITS:0] crd);
        return (u1 && (r1 != '0) && (c1 != '0)) ||
               (u2 && (r2 != '0) && (c2 != '0)) ||
               (wr && (rd != '0) && (crd >= CNT_SAT));
    endfunction

    always_comb begin
        a_hazard = hazard_f(
            a_uses_rs1, a_rs1, eff_cnt(cnt_q[a_rs1], inc_hit && (inc_rd == a_rs1)),
            a_uses_rs2, a_rs2, eff_cnt(cnt_q[a_rs2], inc_hit && (inc_rd == a_rs2)),
            a_writes_rd, a_rd, eff_cnt(cnt_q[a_rd], inc_hit && (inc_rd == a_rd)));
        b_hazard = hazard_f(
            b_uses_rs1, b_rs1, eff_cnt(cnt_q[b_rs1], inc_hit && (inc_rd == b_rs1)),
            b_uses_rs2, b_rs2, eff_cnt(cnt_q[b_rs2], inc_hit && (inc_rd == b_rs2)),
            b_writes_rd, b_rd, eff_cnt(cnt_q[b_rd], inc_hit && (inc_rd == b_rd)));
    end

    // x0 is never counted; a retire against an empty counter is dropped.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            inc_vec[i] = inc_hit && (inc_rd == IDX_W'(i));
            dec_vec[i] = dec_valid && (dec_rd == IDX_W'(i)) && (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core || flush) begin
            for (int i = 0; i < REG_COUNT; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt_q[i] <= cnt_q[i] + PENDING_BITS'(1);
                else if (dec_vec[i] && !inc_vec[i])
                    cnt_q[i] <= cnt_q[i] - PENDING_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/hsv_core_issue_gate.sv
// In-order issue gate: one-entry hold register and IDLE/WAIT/ISSUE FSM that
// releases an instruction only when the scoreboard reports no hazard.
module hsv_core_issue_gate
    import hsv_core_issue_pkg::*;
#(
    parameter int REG_COUNT     = 32,
    parameter int PENDING_BITS  = 2,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  flush,
    hsv_core_issue_gate_if.slave  bus
);

    localparam int IDX_W = $clog2(REG_COUNT);

    issue_state_t             state_q;
    issue_state_t             state_d;
    logic                     ready;
    logic                     accept;
    logic                     fire_wr;
    logic                     haz_in;
    logic                     haz_held;
    logic                     vld_p1;

    logic [PAYLOAD_WIDTH-1:0] payload_p1;
    logic [IDX_W-1:0]         rs1_p1;
    logic [IDX_W-1:0]         rs2_p1;
    logic [IDX_W-1:0]         rd_p1;
    logic                     uses_rs1_p1;
    logic                     uses_rs2_p1;
    logic                     writes_rd_p1;

    assign vld_p1  = (state_q == ISSUE);
    assign accept  = bus.valid_i && ready;
    assign fire_wr = vld_p1 && bus.ready_i && writes_rd_p1 && (rd_p1 != '0);

    hsv_core_issue_scoreboard #(
        .REG_COUNT    (REG_COUNT),
        .PENDING_BITS (PENDING_BITS)
    ) u_sb (
        .clk_core    (clk_core),
        .rst_core    (rst_core),
        .flush       (flush),
        .inc_valid   (fire_wr),
        .inc_rd      (rd_p1),
        .dec_valid   (bus.commit_valid_i),
        .dec_rd      (bus.commit_rd_i),
        .a_uses_rs1  (bus.uses_rs1_i),
        .a_rs1       (bus.rs1_i),
        .a_uses_rs2  (bus.uses_rs2_i),
        .a_rs2       (bus.rs2_i),
        .a_writes_rd (bus.writes_rd_i),
        .a_rd        (bus.rd_i),
        .a_hazard    (haz_in),
        .b_uses_rs1  (uses_rs1_p1),
        .b_rs1       (rs1_p1),
        .b_uses_rs2  (uses_rs2_p1),
        .b_rs2       (rs2_p1),
        .b_writes_rd (writes_rd_p1),
        .b_rd        (rd_p1),
        .b_hazard    (haz_held)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.valid_i) state_d = haz_in ? WAIT : ISSUE;
            end
            WAIT: begin
                if (!haz_held) state_d = ISSUE;
            end
            ISSUE: begin
                if (bus.ready_i) begin
                    ready   = 1'b1;
                    state_d = bus.valid_i ? (haz_in ? WAIT : ISSUE) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Stage p1: hold register, cleared so flushed outputs match reset values.
    always_ff @(posedge clk_core) begin
        if (rst_core || flush) begin
            payload_p1   <= '0;
            rs1_p1       <= '0;
            rs2_p1       <= '0;
            rd_p1        <= '0;
            uses_rs1_p1  <= 1'b0;
            uses_rs2_p1  <= 1'b0;
            writes_rd_p1 <= 1'b0;
        end else if (accept) begin
            payload_p1   <= bus.payload_i;
            rs1_p1       <= bus.rs1_i;
            rs2_p1       <= bus.rs2_i;
            rd_p1        <= bus.rd_i;
            uses_rs1_p1  <= bus.uses_rs1_i;
            uses_rs2_p1  <= bus.uses_rs2_i;
            writes_rd_p1 <= bus.writes_rd_i;
        end
    end

    assign bus.ready_o     = ready;
    assign bus.valid_o     = vld_p1;
    assign bus.payload_o   = payload_p1;
    assign bus.rd_o        = rd_p1;
    assign bus.writes_rd_o = writes_rd_p1;

endmodule

// File: tb/tb_hsv_core_issue_gate.sv
// Directed table-driven bench for hsv_core_issue_gate with hand-computed
// expectations, plus a mid-operation reset sequence.
module tb_hsv_core_issue_gate;
    import hsv_core_issue_pkg::*;

    typedef struct {
        logic        fl;
        logic        v;
        logic        u1;
        reg_idx_t    rs1;
        logic        u2;
        reg_idx_t    rs2;
        logic        wr;
        reg_idx_t    rd;
        logic [63:0] pl;
        logic        rdy;
        logic        cv;
        reg_idx_t    crd;
        logic        evo;
        logic        ero;
        reg_idx_t    erd;
        logic [63:0] epl;
        reg_idx_t    creg;
        logic [1:0]  ecnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    hsv_core_issue_gate_if #(.REG_COUNT(32), .PAYLOAD_WIDTH(64)) bus ();

    hsv_core_issue_gate #(
        .REG_COUNT     (32),
        .PENDING_BITS  (2),
        .PAYLOAD_WIDTH (64)
    ) dut (
        .clk_core (clk),
        .rst_core (rst),
        .flush    (flush),
        .bus      (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, v, u1, input reg_idx_t rs1, input logic u2,
                       input reg_idx_t rs2, input logic wr, input reg_idx_t rd,
                       input logic [63:0] pl, input logic rdy, cv, input reg_idx_t crd,
                       input logic evo, ero, input reg_idx_t erd, input logic [63:0] epl,
                       input reg_idx_t creg, input logic [1:0] ecnt);
        vec_t t;
        t.fl = fl;  t.v = v;    t.u1 = u1;   t.rs1 = rs1; t.u2 = u2; t.rs2 = rs2;
        t.wr = wr;  t.rd = rd;  t.pl = pl;   t.rdy = rdy; t.cv = cv; t.crd = crd;
        t.evo = evo; t.ero = ero; t.erd = erd; t.epl = epl; t.creg = creg; t.ecnt = ecnt;
        vq.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        flush              = t.fl;
        bus.valid_i        = t.v;
        bus.uses_rs1_i     = t.u1;
        bus.rs1_i          = t.rs1;
        bus.uses_rs2_i     = t.u2;
        bus.rs2_i          = t.rs2;
        bus.writes_rd_i    = t.wr;
        bus.rd_i           = t.rd;
        bus.payload_i      = t.pl;
        bus.ready_i        = t.rdy;
        bus.commit_valid_i = t.cv;
        bus.commit_rd_i    = t.crd;
    endtask

    task automatic idle_inputs(input logic rdy);
        vec_t t;
        t = '{default: '0};
        t.rdy = rdy;
        drive(t);
    endtask

    initial begin
        idle_inputs(1'b1);

        // fl v u1 rs1 u2 rs2 wr rd pl rdy cv crd | vo ro rd_o pl_o creg cnt
        add(0,1,0,0,0,0,1, 5,64'hA1,1,0,0, 0,1,0,64'h0 ,5,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 1,1,5,64'hA1,5,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,5, 0,1,5,64'hA1,5,1);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 0,1,5,64'hA1,5,0);
        add(0,1,0,0,0,0,1, 5,64'hB1,0,0,0, 0,1,5,64'hA1,5,0);
        add(0,1,1,5,0,0,1, 6,64'hB2,1,0,0, 1,1,5,64'hB1,5,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 0,0,6,64'hB2,5,1);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,5, 0,0,6,64'hB2,5,1);
        add(0,0,0,0,0,0,0, 0,64'h0 ,0,0,0, 0,0,6,64'hB2,5,0);
        for (int i = 0; i < 5; i++)
            add(0,0,0,0,0,0,0, 0,64'h0,0,0,0, 1,0,6,64'hB2,5,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 1,1,6,64'hB2,6,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,6, 0,1,6,64'hB2,6,1);
        add(0,1,0,0,0,0,1, 3,64'hC1,1,0,0, 0,1,6,64'hB2,6,0);
        add(0,1,0,0,0,0,1, 3,64'hC2,1,0,0, 1,1,3,64'hC1,3,0);
        add(0,1,0,0,0,0,1, 3,64'hC3,1,0,0, 1,1,3,64'hC2,3,1);
        add(0,1,0,0,0,0,1, 3,64'hC4,1,0,0, 1,1,3,64'hC3,3,2);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 0,0,3,64'hC4,3,3);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,3, 0,0,3,64'hC4,3,3);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 0,0,3,64'hC4,3,2);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 1,1,3,64'hC4,3,2);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,3, 0,1,3,64'hC4,3,3);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,3, 0,1,3,64'hC4,3,2);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,3, 0,1,3,64'hC4,3,1);
        add(0,1,0,0,0,0,1, 0,64'hD1,1,0,0, 0,1,3,64'hC4,3,0);
        add(0,1,0,0,0,0,1, 4,64'hD2,1,0,0, 1,1,0,64'hD1,0,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,0,0,0, 1,0,4,64'hD2,4,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 1,1,4,64'hD2,4,0);
        add(0,1,0,0,0,0,1, 4,64'hD3,1,0,0, 0,1,4,64'hD2,4,1);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,4, 1,1,4,64'hD3,4,1);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,4, 0,1,4,64'hD3,4,1);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,4, 0,1,4,64'hD3,4,0);
        add(0,1,0,0,0,0,1, 9,64'hE1,1,0,0, 0,1,4,64'hD3,4,0);
        add(0,1,0,0,0,0,1,10,64'hE2,1,0,0, 1,1,9,64'hE1,9,0);
        add(1,1,0,0,0,0,1,11,64'hE3,1,0,0, 1,1,10,64'hE2,9,1);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 0,1,0,64'h0 ,9,0);
        add(0,1,0,0,0,0,1, 8,64'hF1,1,0,0, 0,1,0,64'h0 ,10,0);
        add(0,1,1,0,1,8,1, 0,64'hF2,1,0,0, 1,1,8,64'hF1,8,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,1,8, 0,0,0,64'hF2,8,1);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 0,0,0,64'hF2,8,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 1,1,0,64'hF2,8,0);
        add(0,0,0,0,0,0,0, 0,64'h0 ,1,0,0, 0,1,0,64'hF2,8,0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            vec_t t;
            t = vq[i];
            @(negedge clk);
            drive(t);
            #1;
            chk($sformatf("row%0d valid_o", i), 64'(bus.valid_o), 64'(t.evo));
            chk($sformatf("row%0d ready_o", i), 64'(bus.ready_o), 64'(t.ero));
            chk($sformatf("row%0d rd_o", i), 64'(bus.rd_o), 64'(t.erd));
            chk($sformatf("row%0d payload_o", i), bus.payload_o, t.epl);
            chk($sformatf("row%0d cnt[%0d]", i, t.creg),
                64'(dut.u_sb.cnt_q[t.creg]), 64'(t.ecnt));
        end

        // Reset arriving while an instruction is being handed over.
        @(negedge clk);
        idle_inputs(1'b0);
        bus.valid_i     = 1'b1;
        bus.writes_rd_i = 1'b1;
        bus.rd_i        = 5'd12;
        bus.payload_i   = 64'h1234;
        @(negedge clk);
        idle_inputs(1'b0);
        #1;
        chk("rst_seq held valid_o", 64'(bus.valid_o), 64'd1);
        chk("rst_seq held payload_o", bus.payload_o, 64'h1234);
        chk("rst_seq held writes_rd_o", 64'(bus.writes_rd_o), 64'd1);
        bus.ready_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs(1'b1);
        #1;
        chk("rst_seq valid_o", 64'(bus.valid_o), 64'd0);
        chk("rst_seq ready_o", 64'(bus.ready_o), 64'd1);
        chk("rst_seq payload_o", bus.payload_o, 64'd0);
        chk("rst_seq rd_o", 64'(bus.rd_o), 64'd0);
        chk("rst_seq writes_rd_o", 64'(bus.writes_rd_o), 64'd0);
        chk("rst_seq cnt[12]", 64'(dut.u_sb.cnt_q[12]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
